// File: rtl/instr_fetch_sequencer.sv
// PC owner and fetch/issue sequencer: one instruction in flight, mem latency + exec latency + 2 cycles each.
// No internal buffering; waits on imem_valid in FETCH and exec_done in ISSUE indefinitely.
module instr_fetch_sequencer #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic              exec_done,
  input  logic              unconditional,
  input  logic [2:0]        conditional,
  input  logic              halt,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_carry,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted,
  output logic [31:0]       retired
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

  state_t state, next_state;
  logic   taken;
  logic   req_d, ivld_d, halted_d;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = FETCH;
      FETCH:   if (imem_valid) next_state = ISSUE;
      ISSUE:   if (exec_done)  next_state = halt ? HALTED : FETCH;
      HALTED:  next_state = HALTED;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    req_d    = (next_state == FETCH);
    ivld_d   = (next_state == ISSUE);
    halted_d = (next_state == HALTED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      imem_req    <= req_d;
      instr_valid <= ivld_d;
      halted      <= halted_d;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (conditional)
      3'b001:  taken = flag_sign;
      3'b010:  taken = flag_zero;
      3'b011:  taken = !flag_zero;
      3'b100:  taken = flag_carry;
      3'b101:  taken = !flag_carry;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
    end else begin
      if (state == FETCH && imem_valid)
        instr <= imem_rdata;
      if (state == ISSUE && exec_done) begin
        retired <= retired + 32'd1;
        // Halt takes priority over any branch request: PC stays on the halt instruction.
        if (!halt) begin
          if (unconditional || taken) pc <= branch_target;
          else                        pc <= pc + ADDR_W'(PC_STEP);
        end
      end
    end
  end

  assign opcode    = instr[31:26];
  assign imem_addr = pc;

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Front end of the KGP-miniRISC core: owns the PC, fetches 32-bit instructions from instruction memory and presents them to the decode stage.
- Drives opcode = instr[31:26] into control_unit and consumes control_unit's branch/halt outputs plus datapath flags to pick the next PC.
- Multi-cycle, one instruction in flight: fetch, issue, wait for execute-done, update PC.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
RESET_PC, 0, PC value after reset
PC_STEP, 4, byte increment for sequential flow

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk edge
imem_req  output  1  instruction-memory read request
imem_addr  output  ADDR_W  read address (equals pc)
imem_rdata  input  32  instruction word, valid when imem_valid=1
imem_valid  input  1  read-data-valid strobe from memory
instr  output  32  captured instruction word
opcode  output  6  instr[31:26], to control_unit
instr_valid  output  1  instr is stable and being executed
pc  output  ADDR_W  address of the current instruction
exec_done  input  1  datapath finished the current instruction (single-cycle pulse)
unconditional  input  1  from control_unit: always-taken branch
conditional  input  3  from control_unit: condition code
halt  input  1  from control_unit: halt instruction
flag_zero, flag_sign, flag_carry  input  1 each  datapath flags for the current instruction
branch_target  input  ADDR_W  datapath-computed target address
halted  output  1  core stopped
retired  output  32  count of completed instructions

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, retired=0. Reset overrides any in-progress fetch or issue, and any outstanding memory request is abandoned.
- States are IDLE, FETCH, ISSUE and HALTED.
- IDLE: always moves to FETCH on the next cycle.
- FETCH: imem_req=1 and imem_addr=pc, held until imem_valid=1, with no timeout. When imem_valid=1, instr<=imem_rdata and the state moves to ISSUE. Memory latency is at least 1 cycle after request and is otherwise arbitrary.
- ISSUE: instr_valid=1, imem_req=0, and instr/opcode are held stable. The block waits for exec_done=1. In that cycle it samples halt, unconditional, conditional, the flags and branch_target, and retired<=retired+1, wrapping modulo 2^32.
- Next PC on exec_done, in priority order:
  - halt=1: pc unchanged, go to HALTED.
  - unconditional=1: pc<=branch_target.
  - taken(conditional)=1: pc<=branch_target.
  - otherwise: pc<=pc+PC_STEP, wrapping modulo 2^ADDR_W.
  - For every non-halt case, go to FETCH.
- taken(conditional):
  - 000: none, 0
  - 001: bltz, flag_sign
  - 010: bz, flag_zero
  - 011: bnz, !flag_zero
  - 100: bcy, flag_carry
  - 101: bncy, !flag_carry
  - 110 and 111: reserved, treated as 0
- HALTED: halted=1, instr_valid=0, imem_req=0. The block stays here until reset, and all other inputs are ignored.
- imem_valid is ignored outside FETCH. exec_done is ignored outside ISSUE.
- halt and a branch asserted together: halt wins, pc is not updated.
- instr_valid deasserts in the cycle after exec_done. Sequential throughput is therefore 1 instruction per (memory latency + execute latency + 2) cycles.
- Outputs are registered, except opcode (a wire slice of instr) and imem_addr (equal to pc).

Test Plan:
- Reset sequence: hold reset=0 for 3 cycles, then release. Required: cycle 1 after release imem_req=1 with imem_addr=0. imem_valid with rdata 0x04000000 one cycle later gives instr_valid=1 and opcode=6'b000001 on the next edge.
- Sequential flow: at pc=0x10, exec_done with no branch or halt. Required: next fetch address 0x14 and retired increments by 1. Also start at pc=0xFFFFFFFC and require wrap to 0x0.
- Conditional branches:
  - conditional=010, flag_zero=1, target 0x80: next address 0x80.
  - Same code with flag_zero=0: next address pc+4.
  - 011, 001, 100, 101 and reserved 111 each checked both ways.
- Halt priority: halt=1 with unconditional=1 and target 0x40. Required: halted=1, pc unchanged, and no imem_req for 20 cycles even with imem_valid/exec_done toggled.
- Reset mid-operation:
  - Assert reset while in FETCH with imem_valid not yet returned: a late imem_valid after release is ignored and the fetch restarts at RESET_PC.
  - Assert reset in HALTED: the block recovers to IDLE, then FETCH.
- Variable latency: memory latency of 1, 5 and 0-then-stall patterns. Required: imem_addr stable while imem_req=1, and instr captured only on the imem_valid cycle.
